// File: rtl/branch_comparator_pkg.sv
// Shared definitions for the RV32I branch comparator.
// Holds the operand width default and the branch funct3 encodings,
// which the instruction decoder uses as well.
package branch_comparator_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned BC_OP_W  = 3;

    // RISC-V branch funct3 encodings; 3'b010 and 3'b011 are reserved
    typedef enum logic [BC_OP_W-1:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } bc_op_e;

    // Comparator result bundle passed from the core to the opcode mux
    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } cmp_flags_t;

endpackage : branch_comparator_pkg

// File: rtl/branch_comparator_cmp_core.sv
// Combinational operand comparator.
// Ports:
//   op_a, op_b : XLEN-bit operands (rs1, rs2)
//   flags      : eq, signed less-than, unsigned less-than of op_a vs op_b
module branch_cmp_core
    import branch_comparator_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output cmp_flags_t      flags
);

    // Full-width compares; the MSB acts as sign bit for the signed one
    always_comb begin
        flags     = '0;
        flags.eq  = (op_a == op_b);
        flags.lt  = ($signed(op_a) < $signed(op_b));
        flags.ltu = (op_a < op_b);
    end

endmodule : branch_cmp_core

// File: rtl/branch_comparator.sv
// RV32I branch-condition evaluator for the execute stage.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   data_in1, data_in2 : operands rs1, rs2
//   bc_op              : branch funct3
//   bc_out             : combinational branch-taken result for PC select
//   bc_out_q           : bc_out registered on the rising clk edge
//   eq_flag, lt_flag, ltu_flag : combinational compare flags
module branch_comparator
    import branch_comparator_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     data_in1,
    input  logic [XLEN-1:0]     data_in2,
    input  logic [BC_OP_W-1:0]  bc_op,
    output logic                bc_out,
    output logic                bc_out_q,
    output logic                eq_flag,
    output logic                lt_flag,
    output logic                ltu_flag
);

    cmp_flags_t flags;
    logic       bc_out_d;

    branch_cmp_core #(
        .XLEN (XLEN)
    ) u_core (
        .op_a  (data_in1),
        .op_b  (data_in2),
        .flags (flags)
    );

    // Opcode mux; reserved or unknown opcodes resolve to not-taken
    always_comb begin
        bc_out_d = 1'b0;
        case (bc_op)
            BEQ:     bc_out_d = flags.eq;
            BNE:     bc_out_d = ~flags.eq;
            BLT:     bc_out_d = flags.lt;
            BGE:     bc_out_d = ~flags.lt;
            BLTU:    bc_out_d = flags.ltu;
            BGEU:    bc_out_d = ~flags.ltu;
            default: bc_out_d = 1'b0;
        endcase
    end

    assign bc_out   = bc_out_d;
    assign eq_flag  = flags.eq;
    assign lt_flag  = flags.lt;
    assign ltu_flag = flags.ltu;

    // Registered copy for pipeline/debug consumers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_out_q <= 1'b0;
        end else begin
            bc_out_q <= bc_out_d;
        end
    end

endmodule : branch_comparator

// File: tb/tb_branch_comparator.sv
// Self-checking bench for branch_comparator.
module tb_branch_comparator;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in1;
    logic [31:0] data_in2;
    logic [2:0]  bc_op;
    logic        bc_out;
    logic        bc_out_q;
    logic        eq_flag;
    logic        lt_flag;
    logic        ltu_flag;

    int n_total = 0;
    int n_pass  = 0;

    // Directed literal expectations, checked at the next falling edge
    logic lit_bc_en = 1'b0, lit_bc = 1'b0;
    logic lit_eq_en = 1'b0, lit_eq = 1'b0;
    logic lit_fl_en = 1'b0, lit_lt = 1'b0, lit_ltu = 1'b0;
    logic lit_q_en  = 1'b0, lit_q  = 1'b0;
    logic done      = 1'b0;

    logic exp_q = 1'b0;

    branch_comparator #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .bc_op    (bc_op),
        .bc_out   (bc_out),
        .bc_out_q (bc_out_q),
        .eq_flag  (eq_flag),
        .lt_flag  (lt_flag),
        .ltu_flag (ltu_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand as a mathematical integer, signed or unsigned interpretation
    function automatic longint as_int(input logic [31:0] v, input bit signed_view);
        longint r;
        r = longint'({32'h0, v});
        if (signed_view && v[31]) r = r - 64'sh1_0000_0000;
        return r;
    endfunction

    function automatic logic m_eq(input logic [31:0] a, input logic [31:0] b);
        return as_int(a, 1'b0) == as_int(b, 1'b0);
    endfunction

    function automatic logic m_lt(input logic [31:0] a, input logic [31:0] b);
        return as_int(a, 1'b1) < as_int(b, 1'b1);
    endfunction

    function automatic logic m_ltu(input logic [31:0] a, input logic [31:0] b);
        return as_int(a, 1'b0) < as_int(b, 1'b0);
    endfunction

    function automatic logic m_bc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic r;
        case (op)
            3'd0:    r = m_eq(a, b);
            3'd1:    r = !m_eq(a, b);
            3'd4:    r = m_lt(a, b);
            3'd5:    r = !m_lt(a, b);
            3'd6:    r = m_ltu(a, b);
            3'd7:    r = !m_ltu(a, b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Reference for the registered output
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q = 1'b0;
        else        exp_q = m_bc(data_in1, data_in2, bc_op);
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (in1=%h in2=%h op=%0d t=%0t)",
                      name, act, exp, data_in1, data_in2, bc_op, $time);
    endtask

    // Single compare process: model every cycle plus any directed literal
    always @(negedge clk) begin
        if (!done) begin
            chk("bc_out",   bc_out,   m_bc(data_in1, data_in2, bc_op));
            chk("eq_flag",  eq_flag,  m_eq(data_in1, data_in2));
            chk("lt_flag",  lt_flag,  m_lt(data_in1, data_in2));
            chk("ltu_flag", ltu_flag, m_ltu(data_in1, data_in2));
            chk("bc_out_q", bc_out_q, exp_q);
            if (lit_bc_en) chk("lit_bc_out", bc_out, lit_bc);
            if (lit_eq_en) chk("lit_eq_flag", eq_flag, lit_eq);
            if (lit_fl_en) begin
                chk("lit_lt_flag",  lt_flag,  lit_lt);
                chk("lit_ltu_flag", ltu_flag, lit_ltu);
            end
            if (lit_q_en) chk("lit_bc_out_q", bc_out_q, lit_q);
        end
    end

    task automatic clear_lits();
        lit_bc_en = 1'b0;
        lit_eq_en = 1'b0;
        lit_fl_en = 1'b0;
        lit_q_en  = 1'b0;
    endtask

    // Drive new inputs shortly after a rising edge
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(posedge clk);
        #2;
        data_in1 = a;
        data_in2 = b;
        bc_op    = op;
        clear_lits();
    endtask

    logic [2:0] ops [6];
    logic [5:0] exp_v1, exp_v2, exp_v3;

    task automatic sweep(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] exp_bits, input bit chk_eq);
        for (int i = 0; i < 6; i++) begin
            apply(a, b, ops[i]);
            lit_bc_en = 1'b1;
            lit_bc    = exp_bits[5-i];
            if (chk_eq) begin
                lit_eq_en = 1'b1;
                lit_eq    = 1'b1;
            end
        end
    endtask

    initial begin
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
        ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;
        exp_v1 = 6'b011001;
        exp_v2 = 6'b100101;
        exp_v3 = 6'b010110;

        rst_n    = 1'b0;
        data_in1 = 32'h1234_5678;
        data_in2 = 32'h1234_5678;
        bc_op    = 3'b000;

        // Held in reset: register stays cleared while bc_out is already 1
        for (int i = 0; i < 3; i++) begin
            apply(32'h1234_5678, 32'h1234_5678, 3'b000);
            lit_q_en  = 1'b1;
            lit_q     = 1'b0;
            lit_bc_en = 1'b1;
            lit_bc    = 1'b1;
        end

        // Release between edges: no edge yet, still 0
        apply(32'h1234_5678, 32'h1234_5678, 3'b000);
        rst_n    = 1'b1;
        lit_q_en = 1'b1;
        lit_q    = 1'b0;
        // After the first rising edge the register holds 1
        apply(32'h1234_5678, 32'h1234_5678, 3'b000);
        lit_q_en = 1'b1;
        lit_q    = 1'b1;

        // Reset dropped mid-cycle clears only the register
        apply(32'h1234_5678, 32'h1234_5678, 3'b000);
        rst_n     = 1'b0;
        lit_q_en  = 1'b1;
        lit_q     = 1'b0;
        lit_bc_en = 1'b1;
        lit_bc    = 1'b1;
        apply(32'h1234_5678, 32'h1234_5678, 3'b000);
        rst_n = 1'b1;

        sweep(32'hff78_6510, 32'h1096_bc81, exp_v1, 1'b0);
        sweep(32'h1234_5678, 32'h1234_5678, exp_v2, 1'b1);
        sweep(32'h497b_dc52, 32'he6ba_817f, exp_v3, 1'b0);

        // Reserved opcodes are never taken
        apply(32'h1234_5678, 32'h1234_5678, 3'b010);
        lit_bc_en = 1'b1; lit_bc = 1'b0;
        apply(32'h0000_0001, 32'h8000_0000, 3'b011);
        lit_bc_en = 1'b1; lit_bc = 1'b0;

        // Sign boundary cases
        apply(32'h8000_0000, 32'h7fff_ffff, 3'b100);
        lit_fl_en = 1'b1; lit_lt = 1'b1; lit_ltu = 1'b0;
        lit_bc_en = 1'b1; lit_bc = 1'b1;
        apply(32'h0000_0000, 32'hffff_ffff, 3'b110);
        lit_fl_en = 1'b1; lit_lt = 1'b0; lit_ltu = 1'b1;
        lit_bc_en = 1'b1; lit_bc = 1'b1;

        // Registered path follows one cycle behind across changing results
        apply(32'h0000_0005, 32'h0000_0005, 3'b001);
        apply(32'h0000_0005, 32'h0000_0005, 3'b000);
        lit_q_en = 1'b1; lit_q = 1'b0;
        apply(32'h0000_0003, 32'h0000_0005, 3'b111);
        lit_q_en = 1'b1; lit_q = 1'b1;

        // Pseudo-random vectors against the model
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            apply(a, b, 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        #2;
        clear_lits();
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_branch_comparator

// File: doc/branch_comparator.md
Name: branch_comparator

Overview:
- RV32I branch-condition evaluator in the execute stage. Compares two register operands under a 3-bit branch opcode and asserts taken/not-taken.
- Primary result bc_out is combinational, available in the same cycle for PC-select logic.
- A registered copy is provided for pipeline-register or debug consumers.

Parameters:
- XLEN, 32, operand width in bits.

Ports:
- clk  input  1  system clock; rising-edge registers only.
- rst_n  input  1  asynchronous active-low reset.
- data_in1  input  XLEN  operand rs1.
- data_in2  input  XLEN  operand rs2.
- bc_op  input  3  branch opcode, equal to instruction funct3.
- bc_out  output  1  combinational branch-taken result.
- bc_out_q  output  1  bc_out registered on the clk rising edge.
- eq_flag  output  1  combinational data_in1 == data_in2.
- lt_flag  output  1  combinational signed data_in1 < data_in2.
- ltu_flag  output  1  combinational unsigned data_in1 < data_in2.

Behaviour:
- Opcode encodings are RISC-V funct3 values, taken from the shared defines header:
  - BEQ = 3'b000
  - BNE = 3'b001
  - BLT = 3'b100
  - BGE = 3'b101
  - BLTU = 3'b110
  - BGEU = 3'b111
- bc_out per opcode:
  - BEQ: eq
  - BNE: !eq
  - BLT: lt (two's complement)
  - BGE: !lt
  - BLTU: ltu
  - BGEU: !ltu
- Reserved opcodes 3'b010 and 3'b011 force bc_out = 0 (not taken).
- bc_out and the three flags are purely combinational: zero latency, settled within the same cycle as any input change, no dependence on clk or rst_n.
- Signed compare uses the MSB as the sign bit. Full XLEN width; no truncation.
- Equal operands give BEQ=1, BNE=0, BLT=0, BGE=1, BLTU=0, BGEU=1.
- bc_out_q:
  - Asynchronously cleared to 0 when rst_n = 0.
  - Otherwise loads bc_out on every rising clk edge.
  - Exactly one cycle of latency relative to bc_out.
- Reset asserted mid-operation clears only bc_out_q. The combinational outputs keep tracking the inputs.
- X or unknown bc_op must not latch. Use a full case with a default of 0.

Decomposition:
- Shared defines header (defines.vh) holds BEQ, BNE, BLT, BGE, BLTU and BGEU as 3-bit constants. It is also used by the decoder.
- Natural sub-module: branch_cmp_core, a combinational unit producing eq, lt and ltu from the two operands.
- The top level adds the opcode mux and the output register.

Test Plan:
- data_in1=ff786510, data_in2=1096bc81; step bc_op through BEQ, BNE, BLT, BGE, BLTU, BGEU -> bc_out = 0, 1, 1, 0, 0, 1.
- data_in1=data_in2=12345678; same opcode sweep -> bc_out = 1, 0, 0, 1, 0, 1; eq_flag = 1.
- data_in1=497bdc52, data_in2=e6ba817f; same opcode sweep -> bc_out = 0, 1, 0, 1, 1, 0.
- bc_op = 3'b010 and 3'b011 with any operands -> bc_out = 0.
- Boundary values:
  - data_in1=80000000, data_in2=7fffffff -> lt_flag = 1, ltu_flag = 0.
  - data_in1=00000000, data_in2=ffffffff -> lt_flag = 0, ltu_flag = 1.
- Registered path:
  - Hold rst_n low -> bc_out_q = 0.
  - Release rst_n with BEQ and equal operands -> bc_out_q = 1 after the first rising edge.
  - Drop rst_n between edges -> bc_out_q = 0 immediately; bc_out stays 1.
